// File: rtl/i_delay_pkg.sv
// Shared definitions for the I_DELAY tap controller and its helpers.
package i_delay_pkg;

    localparam int DEF_TAP_W = 6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        STEP   = ST_STEP,
        SETTLE = ST_SETTLE,
        CHECK  = ST_CHECK,
        DONE   = ST_DONE
    } state_t;

    localparam logic MODE_SEEK = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/i_delay_settle_timer.sv
// 4-bit loadable down-counter with a zero flag; paces sampling after a
// delay-line control pulse.
module i_delay_settle_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       zero_o
);

    logic [3:0] cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= 4'd0;
        end else if (load_i) begin
            cnt_reg <= load_val_i;
        end else if (en_i && (cnt_reg != 4'd0)) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    assign zero_o = (cnt_reg == 4'd0);

endmodule

// File: rtl/i_delay_tap_ctrl.sv
// Request-driven tap controller for one I_DELAY: restores the programmed tap
// via DLY_LOAD or walks the line one DLY_ADJ step at a time to a target tap.
module i_delay_tap_ctrl
    import i_delay_pkg::*;
#(
    parameter int TAP_W         = DEF_TAP_W,
    parameter int MAX_TAP       = 63,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_load_i,
    input  logic [TAP_W-1:0] req_tap_i,
    output logic             dly_ld_o,
    output logic             dly_adj_o,
    output logic             dly_incdec_o,
    input  logic [TAP_W-1:0] dly_tap_val_i,
    output logic             done_valid_o,
    output logic [TAP_W-1:0] done_tap_o,
    output logic             done_err_o
);

    localparam int               CNT_W       = TAP_W + 1;
    localparam logic [TAP_W-1:0] MAX_TAP_V   = TAP_W'(MAX_TAP);
    localparam logic [CNT_W-1:0] STEP_LIMIT  = CNT_W'(MAX_TAP + 1);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_reg,    state_next;
    logic             mode_reg,     mode_next;
    logic [TAP_W-1:0] tgt_reg,      tgt_next;
    logic [TAP_W-1:0] prev_tap_reg, prev_tap_next;
    logic [CNT_W-1:0] step_cnt_reg, step_cnt_next;
    logic             dir_reg,      dir_next;
    logic [TAP_W-1:0] done_tap_reg, done_tap_next;
    logic             err_reg,      err_next;
    logic             settle_zero;

    i_delay_settle_timer u_settle (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     ((state_reg == LOAD) || (state_reg == STEP)),
        .load_val_i (SETTLE_INIT),
        .en_i       (state_reg == SETTLE),
        .zero_o     (settle_zero)
    );

    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        tgt_next      = tgt_reg;
        prev_tap_next = prev_tap_reg;
        step_cnt_next = step_cnt_reg;
        dir_next      = dir_reg;
        done_tap_next = done_tap_reg;
        err_next      = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    mode_next     = req_load_i;
                    tgt_next      = (req_tap_i > MAX_TAP_V) ? MAX_TAP_V : req_tap_i;
                    step_cnt_next = '0;
                    prev_tap_next = dly_tap_val_i;
                    state_next    = req_load_i ? LOAD : CHECK;
                end
            end
            LOAD: state_next = SETTLE;
            STEP: begin
                step_cnt_next = step_cnt_reg + 1'b1;
                state_next    = SETTLE;
            end
            SETTLE: begin
                if (settle_zero) state_next = CHECK;
            end
            CHECK: begin
                prev_tap_next = dly_tap_val_i;
                done_tap_next = dly_tap_val_i;
                state_next    = DONE;
                err_next      = 1'b0;
                if (mode_reg == MODE_LOAD) begin
                    tgt_next = dly_tap_val_i;
                end else if ((step_cnt_reg != '0) && (dly_tap_val_i == prev_tap_reg)) begin
                    err_next = 1'b1;
                end else if (dly_tap_val_i == tgt_reg) begin
                    err_next = 1'b0;
                end else if (step_cnt_reg == STEP_LIMIT) begin
                    err_next = 1'b1;
                end else begin
                    // No completion yet: keep the last reported tap and walk one step
                    done_tap_next = done_tap_reg;
                    dir_next      = (dly_tap_val_i < tgt_reg);
                    state_next    = STEP;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            mode_reg     <= MODE_SEEK;
            tgt_reg      <= '0;
            prev_tap_reg <= '0;
            step_cnt_reg <= '0;
            dir_reg      <= 1'b0;
            done_tap_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            tgt_reg      <= tgt_next;
            prev_tap_reg <= prev_tap_next;
            step_cnt_reg <= step_cnt_next;
            dir_reg      <= dir_next;
            done_tap_reg <= done_tap_next;
            err_reg      <= err_next;
        end
    end

    assign req_ready_o  = (state_reg == IDLE);
    assign dly_ld_o     = (state_reg == LOAD);
    assign dly_adj_o    = (state_reg == STEP);
    // Present the new direction during CHECK so it is set up a cycle ahead of the adj pulse
    assign dly_incdec_o = (state_reg == CHECK) ? dir_next : dir_reg;
    assign done_valid_o = (state_reg == DONE);
    assign done_tap_o   = done_tap_reg;
    assign done_err_o   = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_i_delay_tap_ctrl.sv
// Self-checking bench for i_delay_tap_ctrl with a behavioural I_DELAY tap model.
module tb_i_delay_tap_ctrl;

    localparam int TAP_W  = 6;
    localparam int MAXT   = 40;
    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_load;
    logic [TAP_W-1:0] req_tap;
    logic             dly_ld, dly_adj, dly_incdec;
    logic [TAP_W-1:0] model_tap = '0;
    logic             done_valid;
    logic [TAP_W-1:0] done_tap;
    logic             done_err;

    logic             preset_en  = 1'b0;
    logic [TAP_W-1:0] preset_val = '0;
    logic [TAP_W-1:0] reload_val = '0;
    logic             stuck      = 1'b0;

    always #5 clk = ~clk;

    i_delay_tap_ctrl #(.TAP_W(TAP_W), .MAX_TAP(MAXT), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_load_i    (req_load),
        .req_tap_i     (req_tap),
        .dly_ld_o      (dly_ld),
        .dly_adj_o     (dly_adj),
        .dly_incdec_o  (dly_incdec),
        .dly_tap_val_i (model_tap),
        .done_valid_o  (done_valid),
        .done_tap_o    (done_tap),
        .done_err_o    (done_err)
    );

    // Delay line model: load restores reload_val, adj moves one tap, saturating
    always @(posedge clk) begin
        if (preset_en) model_tap <= preset_val;
        else if (dly_ld) model_tap <= reload_val;
        else if (dly_adj && !stuck) begin
            if (dly_incdec) begin
                if (model_tap != 6'd63) model_tap <= model_tap + 6'd1;
            end else if (model_tap != 6'd0) begin
                model_tap <= model_tap - 6'd1;
            end
        end
    end

    typedef struct {
        bit load; int init; int req; int reload; bit stk;
        int exp_tap; int exp_err; int exp_lat; int exp_adj; int exp_ld; int exp_dir;
    } vec_t;
    typedef struct { int tap; int err; int lat; int adj; int ld; int dir; } exp_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   total = 0, bad = 0;
    int   cyc = 0, acc_cyc = 0, last_adj = -1, adj_cnt = 0, ld_cnt = 0;
    int   done_seen = 0, spurious = 0;
    logic prev_incdec = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (sb.size() != 0) begin
            if (dly_ld || dly_adj) check("ld_adj_exclusive", int'(dly_ld && dly_adj), 0);
            if (dly_ld) ld_cnt++;
            if (dly_adj) begin
                adj_cnt++;
                check("incdec_setup", int'(dly_incdec), int'(prev_incdec));
                check("step_dir", int'(dly_incdec), sb[0].dir);
                if (last_adj >= 0) check("adj_spacing", cyc - last_adj, SETTLE + 2);
                last_adj = cyc;
            end
            if (done_valid) begin
                exp_t e;
                e = sb.pop_front();
                check("latency", cyc - acc_cyc, e.lat);
                check("done_tap", int'(done_tap), e.tap);
                check("done_err", int'(done_err), e.err);
                check("adj_count", adj_cnt, e.adj);
                check("ld_count", ld_cnt, e.ld);
                done_seen = 1;
            end
        end else if (done_valid) begin
            spurious++;
        end
        prev_incdec = dly_incdec;
    endtask

    task automatic start_req(input bit load, input int tap, input exp_t e);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("ready_before_req", int'(req_ready), 1);
        req_valid = 1'b1;
        req_load  = load;
        req_tap   = TAP_W'(tap);
        acc_cyc   = cyc;
        adj_cnt   = 0;
        ld_cnt    = 0;
        last_adj  = -1;
        done_seen = 0;
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n;
        stuck      = v.stk;
        reload_val = TAP_W'(v.reload);
        preset_val = TAP_W'(v.init);
        preset_en  = 1'b1;
        tick();
        preset_en  = 1'b0;
        e = '{tap: v.exp_tap, err: v.exp_err, lat: v.exp_lat, adj: v.exp_adj, ld: v.exp_ld, dir: v.exp_dir};
        start_req(v.load, v.req, e);
        n = 0;
        while (!done_seen && n < 400) begin tick(); n++; end
        check("done_seen", done_seen, 1);
        tick();
        check("ready_after_done", int'(req_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        exp_t e;
        // load init  req reload stk | tap err lat adj ld dir
        vecs[0] = '{0, 10, 10,  0, 0, 10, 0,   2,  0, 0, 0};
        vecs[1] = '{0, 10, 13,  0, 0, 13, 0,  20,  3, 0, 1};
        vecs[2] = '{0, 20, 17,  0, 0, 17, 0,  20,  3, 0, 0};
        vecs[3] = '{1,  5,  0, 32, 0, 32, 0,   7,  0, 1, 0};
        vecs[4] = '{0,  5,  9,  0, 1,  5, 1,   8,  1, 0, 1};
        vecs[5] = '{0, 10, 50,  0, 0, 40, 0, 182, 30, 0, 1};
        vecs[6] = '{0,  0,  0,  0, 0,  0, 0,   2,  0, 0, 0};
        vecs[7] = '{0, 40, 63,  0, 0, 40, 0,   2,  0, 0, 0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_tap   = '0;
        #1;
        check("rst_ready",      int'(req_ready), 1);
        check("rst_ld",         int'(dly_ld), 0);
        check("rst_adj",        int'(dly_adj), 0);
        check("rst_incdec",     int'(dly_incdec), 0);
        check("rst_done_valid", int'(done_valid), 0);
        check("rst_done_tap",   int'(done_tap), 0);
        check("rst_done_err",   int'(done_err), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            $display("vec %0d: load=%0d init=%0d req=%0d stuck=%0d", i, vecs[i].load,
                     vecs[i].init, vecs[i].req, vecs[i].stk);
            run_vec(vecs[i]);
        end

        // Reset while the line is settling after the first step of a long seek
        stuck      = 1'b0;
        preset_val = 6'd10;
        preset_en  = 1'b1;
        tick();
        preset_en  = 1'b0;
        e = '{tap: 30, err: 0, lat: 122, adj: 20, ld: 0, dir: 1};
        start_req(1'b0, 30, e);
        tick();
        tick();
        check("mid_seek_in_settle", int'(!req_ready && !dly_adj && !done_valid), 1);
        rst = 1'b1;
        #1;
        check("midrst_ready",      int'(req_ready), 1);
        check("midrst_adj",        int'(dly_adj), 0);
        check("midrst_incdec",     int'(dly_incdec), 0);
        check("midrst_done_valid", int'(done_valid), 0);
        check("midrst_done_tap",   int'(done_tap), 0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 150; i++) tick();
        check("no_done_after_reset", spurious, 0);
        check("idle_after_reset", int'(req_ready), 1);
        $display("reset mid-seek: idle window %0d cycles", 150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i_delay_tap_ctrl.md
Name: i_delay_tap_ctrl

Overview:
Control-side initiator for an I_DELAY tap interface. It accepts tap requests over a valid/ready handshake and drives the DLY_LOAD, DLY_ADJ and DLY_INCDEC pulses into the delay line. It reads DLY_TAP_VALUE back and steps the line until the requested tap is reached. It sits in fabric between a calibration engine and one I_DELAY instance, on the same clock as the delay's CLK_IN.

Parameters:
TAP_W, 6, width of the tap value bus.
MAX_TAP, 63, highest legal tap. Targets above it are clamped to MAX_TAP.
SETTLE_CYCLES, 4, wait cycles after each ld/adj pulse before sampling the tap value. Legal range is 1 to 15.

Ports:
clk_i  in  1  sole clock; also drives I_DELAY CLK_IN
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  high only in IDLE
req_load_i  in  1  1 = restore the delay's programmed tap via DLY_LOAD; 0 = seek to target
req_tap_i  in  TAP_W  target tap; used only when req_load_i=0
dly_ld_o  out  1  to I_DELAY DLY_LOAD, one-cycle pulse
dly_adj_o  out  1  to I_DELAY DLY_ADJ, one-cycle pulse
dly_incdec_o  out  1  to I_DELAY DLY_INCDEC; 1 = increment
dly_tap_val_i  in  TAP_W  from I_DELAY DLY_TAP_VALUE
done_valid_o  out  1  one-cycle completion pulse
done_tap_o  out  TAP_W  tap sampled at completion; held until the next completion
done_err_o  out  1  qualifies done_valid_o: tap stuck or step budget exceeded

Behaviour:
- Reset (async assert):
  - state=IDLE.
  - All outputs 0 except req_ready_o=1.
  - done_tap_o=0.
  - Reset mid-operation abandons the operation immediately; no done pulse is produced.
- States: IDLE, LOAD, STEP, SETTLE, CHECK, DONE.
- IDLE:
  - req_ready_o=1.
  - Accept on req_valid_i && req_ready_o in cycle T. Latch the mode and tgt = min(req_tap_i, MAX_TAP).
  - Next state is LOAD if the load mode is selected, else CHECK.
  - step_cnt=0; prev_tap=dly_tap_val_i.
- LOAD: dly_ld_o=1 for exactly one cycle, then SETTLE.
- SETTLE:
  - Counter runs from SETTLE_CYCLES-1 down to 0, then CHECK.
  - dly_incdec_o holds its last value here.
- CHECK (load mode): tgt := dly_tap_val_i, then DONE with err=0.
- CHECK (seek mode), in priority order:
  - If step_cnt>0 and dly_tap_val_i==prev_tap → DONE, err=1. This is the stuck condition.
  - Else if dly_tap_val_i==tgt → DONE, err=0.
  - Else if step_cnt==MAX_TAP+1 → DONE, err=1.
  - Else → STEP with direction = (dly_tap_val_i < tgt).
  - In every case prev_tap := dly_tap_val_i.
- STEP:
  - dly_incdec_o=direction, registered on CHECK exit.
  - dly_adj_o=1 for one cycle; step_cnt++; then SETTLE.
  - dly_incdec_o is stable from the cycle before the adj pulse through the pulse and beyond.
- DONE:
  - done_valid_o=1 for one cycle.
  - done_tap_o=dly_tap_val_i sampled in the preceding CHECK.
  - Next state IDLE; req_ready_o=1 in the following cycle.
- Latency, with accept at T:
  - Seek with target already equal: CHECK at T+1, done_valid_o at T+2.
  - Each step adds SETTLE_CYCLES+2 cycles (STEP + SETTLE + CHECK). Seeking n taps gives done at T+2+n*(SETTLE_CYCLES+2).
  - Load: done at T+3+SETTLE_CYCLES.
- Boundaries:
  - req_valid_i while busy is ignored; the requester holds it.
  - dly_ld_o and dly_adj_o are never high in the same cycle.
  - No back-to-back adj pulses closer than SETTLE_CYCLES+2.
  - Requests are never queued.
- Width rules:
  - Comparisons are unsigned TAP_W.
  - step_cnt is TAP_W+1 bits and never wraps.

Decomposition:
- Package i_delay_pkg holds:
  - TAP_W default.
  - State enum typedef.
  - Mode localparams MODE_SEEK=0, MODE_LOAD=1.
- Sub-module i_delay_settle_timer: 4-bit load/count-down with a zero flag, reusable for a future O_DELAY controller.

Test Plan:
- Reset mid-seek: assert rst_i during SETTLE → outputs 0, req_ready_o=1 same cycle, no done_valid_o afterwards.
- Tap model at 10, seek to 10 at T → done_valid_o at T+2, done_tap_o=10, err=0, no adj pulse.
- Tap model at 10, seek 13 (SETTLE=4) → 3 adj pulses with incdec=1, 6 cycles apart; done at T+20, done_tap_o=13, err=0.
- Tap model at 20, seek 17 → 3 adj pulses with incdec=0; done_tap_o=17, err=0.
- Load request, model reloads to 32 on ld → one dly_ld_o pulse, no adj pulses; done at T+7, done_tap_o=32, err=0.
- Stuck model (tap frozen at 5), seek 9 → one adj pulse, done_err_o=1, done_tap_o=5.
- MAX_TAP=40, seek 50 → clamped, done_tap_o=40, err=0.
